// File: rtl/legv8_branch_pkg.sv
// Shared types and condition-code evaluation for the LEGv8 branch resolver.
package legv8_branch_pkg;

  typedef enum logic [1:0] {BR_B, BR_CBZ, BR_CBNZ, BR_BCOND} br_type_t;

  typedef enum logic [3:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Control fields of a request parked in the first stage
  typedef struct packed {
    br_type_t typ;
    cond_t    cond;
    logic     z;
  } s1_ctrl_t;

  function automatic logic cond_eval(cond_t c, logic [3:0] f);
    logic n, z, cf, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cf = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      EQ: return z;
      NE: return !z;
      HS: return cf;
      LO: return !cf;
      MI: return n;
      PL: return !n;
      VS: return v;
      VC: return !v;
      HI: return cf && !z;
      LS: return !cf || z;
      GE: return n == v;
      LT: return n != v;
      GT: return !z && (n == v);
      LE: return z || (n != v);
      default: return 1'b1;  // AL and NV both always execute
    endcase
  endfunction

endpackage

// File: rtl/zero_detect64.sv
// Combinational zero detector: 16-bit NOR groups AND-combined.
module zero_detect64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero
);

  localparam int NGRP = (WIDTH + 15) / 16;

  logic [NGRP*16-1:0] pad;
  logic [NGRP-1:0]    grp_z;

  // Upper pad bits stay zero so a partial top group still reports correctly
  always_comb begin
    pad            = '0;
    pad[WIDTH-1:0] = data;
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign grp_z[g] = ~|pad[g*16 +: 16];
  end

  assign zero = &grp_z;

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver (B, CBZ, CBNZ, B.cond) that also owns the NZCV flags.
module branch_resolve_unit
  import legv8_branch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             flag_we,
  input  logic [3:0]       flag_in,
  output logic [3:0]       flags_out,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [1:0]       br_type,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] br_operand,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] br_offset,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [WIDTH-1:0] res_target
);

  logic             s1_valid;
  s1_ctrl_t         s1_ctrl;
  logic [WIDTH-1:0] s1_pc;
  logic [WIDTH-1:0] s1_offset;

  logic       op_zero;
  logic       en;
  logic       acc;
  logic       adv;
  logic       taken_d;
  logic [3:0] fwd_flags;

  zero_detect64 #(.WIDTH(WIDTH)) u_zd (
    .data (br_operand),
    .zero (op_zero)
  );

  assign en        = !res_valid || res_ready;
  assign br_ready  = !s1_valid || en;
  assign acc       = br_valid && br_ready;
  assign adv       = s1_valid && en;
  // A flag write landing in the advance cycle is visible to B.cond immediately
  assign fwd_flags = flag_we ? flag_in : flags_out;

  always_comb begin
    taken_d = 1'b1;
    case (s1_ctrl.typ)
      BR_B:     taken_d = 1'b1;
      BR_CBZ:   taken_d = s1_ctrl.z;
      BR_CBNZ:  taken_d = !s1_ctrl.z;
      BR_BCOND: taken_d = cond_eval(s1_ctrl.cond, fwd_flags);
      default:  taken_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_out <= '0;
    else if (flag_we) flags_out <= flag_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_ctrl   <= '{typ: BR_B, cond: EQ, z: 1'b0};
      s1_pc     <= '0;
      s1_offset <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (acc) begin
      s1_valid  <= 1'b1;
      s1_ctrl   <= '{typ: br_type_t'(br_type), cond: cond_t'(br_cond), z: op_zero};
      s1_pc     <= br_pc;
      s1_offset <= br_offset;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (adv) begin
      res_valid  <= 1'b1;
      res_taken  <= taken_d;
      res_target <= s1_pc + s1_offset;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: transaction model of the resolver plus directed and random traffic.
module tb_branch_resolve_unit;
  import legv8_branch_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         flush = 1'b0;
  logic         flag_we = 1'b0;
  logic [3:0]   flag_in = '0;
  logic [3:0]   flags_out;
  logic         br_valid = 1'b0;
  logic         br_ready;
  logic [1:0]   br_type = '0;
  logic [3:0]   br_cond = '0;
  logic [W-1:0] br_operand = '0;
  logic [W-1:0] br_pc = '0;
  logic [W-1:0] br_offset = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic         res_taken;
  logic [W-1:0] res_target;

  int n_chk = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .flags_out  (flags_out),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_type    (br_type),
    .br_cond    (br_cond),
    .br_operand (br_operand),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_taken  (res_taken),
    .res_target (res_target)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Conditions come in complementary pairs; odd codes invert, except NV
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[0] && c != 4'hF) ? !base : base;
  endfunction

  typedef struct {
    logic [1:0]  t;
    logic [3:0]  c;
    logic        z;
    logic [63:0] pc;
    logic [63:0] off;
  } mreq_t;

  function automatic logic ref_taken(input mreq_t r, input logic [3:0] f);
    case (r.t)
      2'd0:    return 1'b1;
      2'd1:    return r.z;
      2'd2:    return !r.z;
      default: return ref_cond(r.c, f);
    endcase
  endfunction

  // Model: one parked request and one presented result
  mreq_t       m_s1;
  logic        m_s1_v, m_out_v, m_taken;
  logic [63:0] m_target;
  logic [3:0]  m_flags;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1_v = 1'b0; m_out_v = 1'b0; m_taken = 1'b0; m_target = '0; m_flags = '0;
    end else begin
      logic [3:0] f;
      logic room, take;
      f    = flag_we ? flag_in : m_flags;
      room = !m_out_v || res_ready;
      take = br_valid && (!m_s1_v || room);
      if (flush) begin
        m_s1_v = 1'b0; m_out_v = 1'b0;
      end else begin
        if (m_s1_v && room) begin
          m_out_v  = 1'b1;
          m_taken  = ref_taken(m_s1, f);
          m_target = m_s1.pc + m_s1.off;
          m_s1_v   = 1'b0;
        end else if (res_ready) begin
          m_out_v = 1'b0;
        end
        if (take) begin
          m_s1   = '{br_type, br_cond, br_operand == 64'd0, br_pc, br_offset};
          m_s1_v = 1'b1;
        end
      end
      if (flag_we) m_flags = flag_in;
    end
  end

  // Compare just before each rising edge, when inputs and outputs are settled
  always @(negedge clk) begin
    #4;
    if (mon_on && reset_n) begin
      chk("m_res_valid", res_valid, m_out_v);
      chk("m_br_ready", br_ready, !m_s1_v || !m_out_v || res_ready);
      chk("m_flags", flags_out, m_flags);
      if (m_out_v) begin
        chk("m_taken", res_taken, m_taken);
        chk("m_target", res_target, m_target);
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [3:0] c, input logic [63:0] op,
                      input logic [63:0] pc, input logic [63:0] off);
    int k = 0;
    br_valid = 1'b1; br_type = t; br_cond = c; br_operand = op; br_pc = pc; br_offset = off;
    #1;
    while (!br_ready && k < 100) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 100) chk("send_timeout", 64'd0, 64'd1);
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    flag_we = 1'b1; flag_in = f;
    @(negedge clk);
    flag_we = 1'b0;
  endtask

  task automatic drain();
    br_valid = 1'b0; res_ready = 1'b1; flush = 1'b0; flag_we = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pats [4];
    logic       acc_now;
    pats = '{4'h0, 4'h9, 4'h6, 4'hF};

    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_taken", res_taken, 0);
    chk("rst_target", res_target, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_ready", br_ready, 1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; mon_on = 1'b1;

    // CBZ taken, one-cycle latency
    send(BR_CBZ, 4'h0, 64'd0, 64'h1000, 64'h40);
    chk("cbz_lat0", res_valid, 0);
    @(posedge clk); #1;
    chk("cbz_valid", res_valid, 1);
    chk("cbz_taken", res_taken, 1);
    chk("cbz_target", res_target, 64'h1040);

    // Back-to-back CBNZ
    @(negedge clk);
    send(BR_CBNZ, 4'h0, 64'h8000_0000_0000_0000, 64'h2000, 64'h8);
    send(BR_CBNZ, 4'h0, 64'd0, 64'h2004, 64'h8);
    #1;
    chk("cbnz1_valid", res_valid, 1);
    chk("cbnz1_taken", res_taken, 1);
    @(posedge clk); #1;
    chk("cbnz2_valid", res_valid, 1);
    chk("cbnz2_taken", res_taken, 0);

    // B.cond with Z set, then forwarding of a same-cycle flag write
    drain();
    load_flags(4'b0100);
    send(BR_BCOND, EQ, 64'd0, 64'h3000, 64'h10);
    @(posedge clk); #1;
    chk("eq_taken", res_taken, 1);
    @(negedge clk);
    send(BR_BCOND, NE, 64'd0, 64'h3000, 64'h10);
    @(posedge clk); #1;
    chk("ne_taken", res_taken, 0);
    @(negedge clk);
    load_flags(4'b0100);
    send(BR_BCOND, EQ, 64'd0, 64'h3000, 64'h10);
    flag_we = 1'b1; flag_in = 4'b0000;
    @(posedge clk); #1;
    chk("eq_fwd_taken", res_taken, 0);
    @(negedge clk);
    flag_we = 1'b0;

    // Full condition sweep
    foreach (pats[p]) begin
      load_flags(pats[p]);
      for (int c = 0; c < 16; c++) begin
        send(BR_BCOND, 4'(c), 64'd0, 64'h4000, 64'(c * 4));
        @(posedge clk); #1;
        chk("sweep_taken", res_taken, ref_cond(4'(c), pats[p]));
        if (c >= 14) chk("al_nv_taken", res_taken, 1);
        @(negedge clk);
      end
    end

    // Stall with three offered requests
    drain();
    res_ready = 1'b0;
    br_valid = 1'b1; br_type = BR_B; br_cond = '0; br_operand = '0;
    br_pc = 64'h100; br_offset = 64'h4;
    for (int i = 0; i < 3; i++) begin
      #1;
      acc_now = br_ready;
      if (i == 2) chk("stall_ready", br_ready, 0);
      @(posedge clk); #1;
      if (i == 0) chk("stall_v0", res_valid, 0);
      else begin
        chk("stall_valid", res_valid, 1);
        chk("stall_target", res_target, 64'h104);
      end
      @(negedge clk);
      if (acc_now) br_pc = br_pc + 64'h100;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("order_1", res_target, 64'h204);
    @(negedge clk);
    br_valid = 1'b0;
    @(posedge clk); #1;
    chk("order_2_valid", res_valid, 1);
    chk("order_2", res_target, 64'h304);

    // PC wrap
    @(negedge clk);
    send(BR_B, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    @(posedge clk); #1;
    chk("wrap_target", res_target, 64'h10);
    chk("wrap_taken", res_taken, 1);

    // Flush with two in flight, plus a same-cycle offer
    drain();
    send(BR_B, 4'h0, 64'd0, 64'h500, 64'h0);
    send(BR_B, 4'h0, 64'd0, 64'h600, 64'h0);
    flush = 1'b1; br_valid = 1'b1; br_pc = 64'h700;
    @(negedge clk);
    flush = 1'b0; br_valid = 1'b0;
    #1;
    chk("flush_valid", res_valid, 0);
    chk("flush_ready", br_ready, 1);
    @(negedge clk); #1;
    chk("flush_nostale", res_valid, 0);

    // Async reset during a stall
    drain();
    load_flags(4'hA);
    res_ready = 1'b0;
    send(BR_B, 4'h0, 64'd0, 64'h800, 64'h4);
    send(BR_B, 4'h0, 64'd0, 64'h900, 64'h4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_taken", res_taken, 0);
    chk("arst_target", res_target, 0);
    chk("arst_flags", flags_out, 0);
    chk("arst_ready", br_ready, 1);
    @(negedge clk);
    reset_n = 1'b1; res_ready = 1'b1;
    @(negedge clk); #1;
    chk("arst_noreplay", res_valid, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      br_valid  = ($urandom_range(0, 3) != 0);
      br_type   = 2'($urandom_range(0, 3));
      br_cond   = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       br_operand = '0;
        1:       br_operand = 64'd1 << $urandom_range(0, 63);
        default: br_operand = {$urandom, $urandom};
      endcase
      br_pc     = {$urandom, $urandom};
      br_offset = {$urandom, $urandom};
      res_ready = ($urandom_range(0, 3) != 0);
      flag_we   = ($urandom_range(0, 4) == 0);
      flag_in   = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 19) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
